// File: rtl/anatool_sar_ctrl.sv
// anatool_sar_ctrl: successive-approximation sequencer for the analog toolkit.
// Drives a trial code into the PWM compare bank, waits a programmable settle
// window per bit, samples the synchronized comparator and resolves MSB first.
// Optional feature macro: ANATOOL_SAR_MAJ_EN enables a 3-sample majority
// filter on the comparator to reject single-cycle glitches.
module anatool_sar_ctrl #(
  parameter int WIDTH    = 8,
  parameter int SETTLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                comp_in,
  output logic [WIDTH-1:0]    dac_code,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    bit_idx_next;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] cnt_next;
  logic [WIDTH-1:0]    dac_code_next;
  logic [WIDTH-1:0]    result_next;
  logic                result_valid_next;
  logic                done_next;
  logic                busy_next;
  logic                launch;
  logic                sample;

`ifdef ANATOOL_SAR_MAJ_EN
  // The vote window is the live comparator bit plus these two history flops.
  logic [1:0] hist;

  // Shift the comparator into the history every cycle, conversion or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= {hist[0], comp_in};
    end
  end

  assign sample = (comp_in & hist[0]) | (comp_in & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = comp_in;
`endif

  // A new conversion starts from IDLE on start, or straight out of DONE in continuous mode.
  assign launch = !abort && (((state == IDLE) && start) || ((state == DONE) && cont));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision; abort wins over every other request.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)            state_next = IDLE;
        else if (cnt == '0)   state_next = DECIDE;
      end
      DECIDE: begin
        if (abort)                state_next = IDLE;
        else if (bit_idx == '0)   state_next = DONE;
        else                      state_next = SETTLE;
      end
      DONE: begin
        if (cont && !abort) state_next = SETTLE;
        else                state_next = IDLE;
      end
    endcase
  end

  // Next values for the registered datapath and outputs; code edits are pure bit set/clear.
  always_comb begin
    dac_code_next     = dac_code;
    bit_idx_next      = bit_idx;
    cnt_next          = cnt;
    result_next       = result;
    result_valid_next = result_valid;
    done_next         = 1'b0;
    busy_next         = (state_next != IDLE);
    if (launch) begin
      bit_idx_next             = IDX_W'(WIDTH - 1);
      dac_code_next            = '0;
      dac_code_next[WIDTH-1]   = 1'b1;
      cnt_next                 = settle;
      result_valid_next        = 1'b0;
    end else if (!abort) begin
      case (state)
        SETTLE: begin
          if (cnt != '0) cnt_next = cnt - 1'b1;
        end
        DECIDE: begin
          dac_code_next[bit_idx] = sample;
          if (bit_idx != '0) begin
            dac_code_next[bit_idx - 1'b1] = 1'b1;
            bit_idx_next                  = bit_idx - 1'b1;
            cnt_next                      = settle;
          end else begin
            result_next       = dac_code_next;
            result_valid_next = 1'b1;
            done_next         = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register every output and the search bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_code     <= '0;
      bit_idx      <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dac_code     <= dac_code_next;
      bit_idx      <= bit_idx_next;
      cnt          <= cnt_next;
      result       <= result_next;
      result_valid <= result_valid_next;
      done         <= done_next;
      busy         <= busy_next;
    end
  end

endmodule

// File: tb/tb_anatool_sar_ctrl.sv
// tb_anatool_sar_ctrl: self-checking bench for anatool_sar_ctrl.
// A window-counting behavioural model predicts every output each cycle;
// directed scenarios pin latency, search results and abort/reset behaviour.
`timescale 1ns/1ps
module tb_anatool_sar_ctrl;

  localparam int WIDTH    = 8;
  localparam int SETTLE_W = 16;
`ifdef ANATOOL_SAR_MAJ_EN
  localparam int SMIN = 1;
`else
  localparam int SMIN = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                cont = 1'b0;
  logic [SETTLE_W-1:0] settle = '0;
  logic                comp_in;
  logic [WIDTH-1:0]    dac_code;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    result;
  logic                result_valid;

  int                  checks = 0;
  int                  failures = 0;
  int                  comp_mode = 0;
  logic [WIDTH-1:0]    target = '0;
  logic                glitch = 1'b0;

  anatool_sar_ctrl #(.WIDTH(WIDTH), .SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .settle(settle), .comp_in(comp_in), .dac_code(dac_code), .busy(busy),
    .done(done), .result(result), .result_valid(result_valid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // External comparator: vin modelled as target, optionally forced, with an injectable glitch.
  always_comb begin
    logic base;
    case (comp_mode)
      1:       base = 1'b1;
      2:       base = 1'b0;
      default: base = (target >= dac_code);
    endcase
    comp_in = base ^ glitch;
  end

  // Behavioural model: conversion described as per-bit windows of settle+2 cycles.
  logic [WIDTH-1:0] m_code, m_result;
  logic             m_valid, m_busy, m_done;
  int               m_bit, m_win, m_elapsed;
`ifdef ANATOOL_SAR_MAJ_EN
  logic             prev1, prev2;
`endif

  task automatic model_load();
    m_busy    = 1'b1;
    m_bit     = WIDTH - 1;
    m_code    = '0;
    m_code[WIDTH-1] = 1'b1;
    m_valid   = 1'b0;
    m_win     = int'(settle) + 2;
    m_elapsed = 0;
  endtask

  // Advance the model on each clock edge, or clear it on reset.
  always @(posedge clk or negedge rst_n) begin : model_step
    logic s;
    if (!rst_n) begin
      m_code = '0; m_result = '0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_bit = 0; m_win = 0; m_elapsed = 0;
`ifdef ANATOOL_SAR_MAJ_EN
      prev1 = 1'b0; prev2 = 1'b0;
`endif
    end else begin
`ifdef ANATOOL_SAR_MAJ_EN
      s = ((int'(comp_in) + int'(prev1) + int'(prev2)) >= 2);
`else
      s = comp_in;
`endif
      if (!m_busy) begin
        if (start && !abort) model_load();
      end else if (abort) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
        if (cont) model_load();
        else      m_busy = 1'b0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_win) begin
          if (!s) m_code[m_bit] = 1'b0;
          if (m_bit > 0) begin
            m_bit--;
            m_code[m_bit] = 1'b1;
            m_win     = int'(settle) + 2;
            m_elapsed = 0;
          end else begin
            m_result = m_code;
            m_valid  = 1'b1;
            m_done   = 1'b1;
          end
        end
      end
`ifdef ANATOOL_SAR_MAJ_EN
      prev2 = prev1;
      prev1 = comp_in;
`endif
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dac_code !== m_code || busy !== m_busy || done !== m_done ||
          result !== m_result || result_valid !== m_valid) begin
        failures++;
        $display("[TB] FAIL model_cycle t=%0t dac_code=%h/%h busy=%b/%b done=%b/%b result=%h/%h valid=%b/%b (actual/required)",
                 $time, dac_code, m_code, busy, m_busy, done, m_done, result, m_result, result_valid, m_valid);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input int tgt, input int stl, input bit c);
    comp_mode = mode;
    target    = WIDTH'(tgt);
    settle    = SETTLE_W'(stl);
    cont      = c;
  endtask

  // Wait for done; k counts mid-cycle samples after the start edge. lat=-1 if budget expires.
  task automatic waitDone(input int budget, input bit hold, input bit arm, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (glitch) glitch = 1'b0;
      if (arm && m_busy && !m_done && (m_elapsed + 1 == m_win) && m_code == 8'h70) begin
        glitch = 1'b1;
        arm = 1'b0;
      end
      if (done) begin
        lat = k;
        start = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int lat, lat2, dones;
    logic [WIDTH-1:0] codes[$];
    logic [WIDTH-1:0] last;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_dac_code", dac_code, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_valid", result_valid, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic conversion settle=3 target=100");
    applyStimulus(0, 100, 3, 1'b0);
    start = 1'b1;
    waitDone(200, 1'b0, 1'b0, lat);
    checkOutput("t1_latency", lat, 40);
    checkOutput("t1_result", result, 100);
    repeat (5) @(negedge clk);
    checkOutput("t1_valid", result_valid, 1);
    checkOutput("t1_dac_code", dac_code, 100);

    $display("[TB] abort 12 cycles after start");
    applyStimulus(0, 55, 3, 1'b0);
    dones = 0;
    start = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
      if (k == 11) abort = 1'b1;
      if (k == 12) begin
        abort = 1'b0;
        checkOutput("t4_busy_after_abort", busy, 0);
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("t4_no_done", dones, 0);
    checkOutput("t4_result_kept", result, 100);

    $display("[TB] constant comparator");
    applyStimulus(1, 0, 1, 1'b0);
    start = 1'b1;
    waitDone(200, 1'b0, 1'b0, lat);
    checkOutput("t2_all_ones", result, 255);
    @(negedge clk);
    applyStimulus(2, 0, 1, 1'b0);
    codes.delete();
    last = '0;
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy && dac_code != last) begin
        codes.push_back(dac_code);
        last = dac_code;
      end
    end
    checkOutput("t2_all_zeros", result, 0);
    checkOutput("t2_trial_count", codes.size(), WIDTH);
    for (int i = 0; i < WIDTH && i < codes.size(); i++)
      checkOutput($sformatf("t2_trial_%0d", i), codes[i], 1 << (WIDTH - 1 - i));

    $display("[TB] settle=0 with start held");
    @(negedge clk);
    applyStimulus(0, 37, SMIN, 1'b0);
    start = 1'b1;
    waitDone(200, 1'b1, 1'b0, lat);
    dones = (lat >= 0) ? 1 : 0;
    repeat (24) begin
      @(negedge clk);
      if (done) dones++;
    end
`ifndef ANATOOL_SAR_MAJ_EN
    checkOutput("t3_latency", lat, 16);
`endif
    checkOutput("t3_result", result, 37);
    checkOutput("t3_one_done", dones, 1);
    checkOutput("t3_idle_after", busy, 0);

    $display("[TB] glitch in trial 0x70 decide");
    applyStimulus(0, 100, 3, 1'b0);
    start = 1'b1;
    waitDone(200, 1'b0, 1'b1, lat);
`ifdef ANATOOL_SAR_MAJ_EN
    checkOutput("t6_glitch_result", result, 100);
`else
    checkOutput("t6_glitch_result", result, 8'h70);
`endif
    @(negedge clk);

    $display("[TB] continuous mode settle=2 target=200");
    applyStimulus(0, 200, 2, 1'b1);
    start = 1'b1;
    waitDone(200, 1'b0, 1'b0, lat);
    checkOutput("t5_first_result", result, 200);
    waitDone(200, 1'b0, 1'b0, lat2);
    checkOutput("t5_interval", lat2 + 1, WIDTH * (2 + 2) + 1);
    checkOutput("t5_second_result", result, 200);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_dac_code", dac_code, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_valid", result_valid, 0);
    checkOutput("t5_rst_done", done, 0);
    cont = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 30; r++) begin
      applyStimulus(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0,
                    int'($urandom_range(0, 255)), int'($urandom_range(SMIN, 4)),
                    ($urandom_range(0, 3) == 0));
      start = 1'b1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        start  = ($urandom_range(0, 15) == 0);
        abort  = ($urandom_range(0, 79) == 0);
        glitch = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 31) == 0) settle = SETTLE_W'($urandom_range(SMIN, 4));
        if (k > 120) cont = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; glitch = 1'b0; cont = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
